// File: rtl/dpram_pkg.sv
// dpram_pkg: shared types and constants for the FIFO controller that sits
// in front of dual_port_ram.
//   - state_t       : controller FSM states (zero-fill, then normal run)
//   - DATA_WIDTH_DEF: default word width, must match dual_port_ram
//   - ADDR_WIDTH_DEF: default RAM address width
//   - depth_of()    : number of RAM words for a given address width
package dpram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 6;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: synchronous FIFO controller driving dual_port_ram.
// Port A of the RAM is the write port, port B the read port. After reset
// the RAM is zero-filled one word per cycle, then the block runs as a FIFO.
//
// Handshake: a push happens on a rising edge where wr_en=1 and full=0; a pop
// happens on a rising edge where rd_en=1 and empty=0. Requests while full or
// empty are dropped and latch the sticky overflow/underflow flags. A popped
// word appears on rd_data with rd_valid=1 in the cycle after the pop edge;
// there is no backpressure on the read side.
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   wr_en, wr_data    push request and data
//   rd_en             pop request
//   flush             synchronous pointer/count/flag clear (RUN only)
//   rd_data, rd_valid popped word and its qualifier
//   full, empty       push / pop would be rejected
//   count             occupancy, 0..depth
//   init_done         zero-fill finished
//   overflow          sticky: push attempted while full
//   underflow         sticky: pop attempted while empty
//   state_dbg         current FSM state
//   ram_a, ram_addr_a, ram_data_a   RAM port A (write)
//   ram_b, ram_addr_b, ram_data_b   RAM port B (read only, write tied off)
//   ram_out_b         RAM port B registered read data
module dpram_fifo_ctrl
  import dpram_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int addr_width = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic [data_width-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [addr_width:0]   count,
  output logic                  init_done,
  output logic                  overflow,
  output logic                  underflow,
  output state_t                state_dbg,
  output logic                  ram_a,
  output logic [addr_width-1:0] ram_addr_a,
  output logic [data_width-1:0] ram_data_a,
  output logic                  ram_b,
  output logic [addr_width-1:0] ram_addr_b,
  output logic [data_width-1:0] ram_data_b,
  input  logic [data_width-1:0] ram_out_b
);

  localparam int depth = depth_of(addr_width);
  localparam logic [addr_width:0]   depth_cnt = (addr_width+1)'(depth);
  localparam logic [addr_width-1:0] last_addr = addr_width'(depth - 1);

  state_t                state;
  logic [addr_width-1:0] init_ptr;
  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] rd_ptr;
  logic                  run;
  logic                  push;
  logic                  pop;

  assign run = (state == ST_RUN);

  // init_done is registered and low for the whole zero-fill, so it forces
  // both full and empty during INIT without any extra state.
  assign full  = !init_done || (count == depth_cnt);
  assign empty = !init_done || (count == '0);

  // flush wins over push/pop in the same cycle.
  assign push = run && wr_en && !full  && !flush;
  assign pop  = run && rd_en && !empty && !flush;

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      init_ptr  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      init_done <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          rd_valid <= 1'b0;
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == last_addr) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end else begin
            // Pointers are addr_width bits, so they wrap at depth for free.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count + {{addr_width{1'b0}}, push}
                              - {{addr_width{1'b0}}, pop};
            rd_valid <= pop;
            if (wr_en && full)  overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // RAM port A: zero-fill sweep during INIT, FIFO writes during RUN.
  always_comb begin
    ram_a      = 1'b1;
    ram_addr_a = init_ptr;
    ram_data_a = '0;
    if (run) begin
      ram_a      = push;
      ram_addr_a = wr_ptr;
      ram_data_a = wr_data;
    end
  end

  // RAM port B: read only. The RAM registers its output, so the word
  // addressed at the pop edge shows up on ram_out_b in the next cycle,
  // exactly when rd_valid is high.
  assign ram_b      = 1'b0;
  assign ram_data_b = '0;
  assign ram_addr_b = rd_ptr;
  assign rd_data    = ram_out_b;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
module tb_dpram_fifo_ctrl;
  import dpram_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, init_done, overflow, underflow;
  logic [AW:0]   count;
  state_t        state_dbg;
  logic          ram_a, ram_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_data_a, ram_data_b, ram_out_b;

  dpram_fifo_ctrl #(.data_width(DW), .addr_width(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .flush(flush),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .count(count), .init_done(init_done), .overflow(overflow),
    .underflow(underflow), .state_dbg(state_dbg),
    .ram_a(ram_a), .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a),
    .ram_b(ram_b), .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b),
    .ram_out_b(ram_out_b)
  );

  // Behavioural dual-port RAM with registered port-B read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_b) mem[ram_addr_b] <= ram_data_b;
    ram_out_b <= mem[ram_addr_b];
  end

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  bit            m_init_done;
  int            m_init_cnt;
  int            m_wptr, m_rptr;
  bit            m_ovf, m_unf;
  bit            m_pend_valid;
  logic [DW-1:0] m_pend_data;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_init_done  = 0;
    m_init_cnt   = 0;
    m_wptr       = 0;
    m_rptr       = 0;
    m_ovf        = 0;
    m_unf        = 0;
    m_pend_valid = 0;
    m_pend_data  = '0;
  endtask

  task automatic check_status();
    bit e_full, e_empty;
    e_full  = !m_init_done || (exp_q.size() == DEPTH);
    e_empty = !m_init_done || (exp_q.size() == 0);
    check("count",      32'(count),      32'(exp_q.size()));
    check("full",       32'(full),       32'(e_full));
    check("empty",      32'(empty),      32'(e_empty));
    check("init_done",  32'(init_done),  32'(m_init_done));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("underflow",  32'(underflow),  32'(m_unf));
    check("rd_valid",   32'(rd_valid),   32'(m_pend_valid));
    check("ram_addr_b", 32'(ram_addr_b), 32'(m_rptr));
    check("ram_b",      32'(ram_b),      32'(0));
    if (m_pend_valid) check("rd_data", 32'(rd_data), 32'(m_pend_data));
  endtask

  // ---------------- driver ----------------
  // One clock: drive at negedge, check combinational RAM port A, take the
  // edge, advance the model, then check registered status at the next negedge.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
    bit e_push, e_pop, was_full, was_empty;
    wr_en = w; wr_data = d; rd_en = r; flush = f;
    #1;
    was_full  = !m_init_done || (exp_q.size() == DEPTH);
    was_empty = !m_init_done || (exp_q.size() == 0);
    e_push = m_init_done && w && !f && !was_full;
    e_pop  = m_init_done && r && !f && !was_empty;
    if (!m_init_done) begin
      check("init_ram_a",    32'(ram_a),      32'(1));
      check("init_ram_addr", 32'(ram_addr_a), 32'(m_init_cnt));
      check("init_ram_data", 32'(ram_data_a), 32'(0));
    end else begin
      check("ram_a", 32'(ram_a), 32'(e_push));
      if (e_push) begin
        check("ram_addr_a", 32'(ram_addr_a), 32'(m_wptr));
        check("ram_data_a", 32'(ram_data_a), 32'(d));
      end
    end
    @(posedge clk);
    if (!m_init_done) begin
      m_init_cnt++;
      m_pend_valid = 0;
      if (m_init_cnt == DEPTH) m_init_done = 1;
    end else if (f) begin
      exp_q.delete();
      m_wptr = 0; m_rptr = 0;
      m_ovf = 0; m_unf = 0;
      m_pend_valid = 0;
    end else begin
      if (w && was_full)  m_ovf = 1;
      if (r && was_empty) m_unf = 1;
      m_pend_valid = e_pop;
      if (e_pop) begin
        m_pend_data = exp_q.pop_front();
        m_rptr = (m_rptr + 1) % DEPTH;
      end
      if (e_push) begin
        exp_q.push_back(d);
        m_wptr = (m_wptr + 1) % DEPTH;
      end
    end
    @(negedge clk);
    check_status();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wr_en = 0; rd_en = 0; flush = 0;
    #1;
    model_reset();
    check("rst_rd_valid",   32'(rd_valid),   32'(0));
    check("rst_full",       32'(full),       32'(1));
    check("rst_empty",      32'(empty),      32'(1));
    check("rst_count",      32'(count),      32'(0));
    check("rst_init_done",  32'(init_done),  32'(0));
    check("rst_overflow",   32'(overflow),   32'(0));
    check("rst_underflow",  32'(underflow),  32'(0));
    check("rst_ram_a",      32'(ram_a),      32'(1));
    check("rst_ram_addr_a", 32'(ram_addr_a), 32'(0));
    check("rst_ram_data_a", 32'(ram_data_a), 32'(0));
    check("rst_ram_addr_b", 32'(ram_addr_b), 32'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    model_reset();

    // Reset, then zero-fill with ignored random requests.
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cycle(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    check("init_done_after_fill", 32'(init_done), 32'(1));
    check("ovf_after_fill", 32'(overflow), 32'(0));

    // Three pushes, three pops.
    cycle(1, 8'h11, 0, 0);
    cycle(1, 8'h22, 0, 0);
    cycle(1, 8'h33, 0, 0);
    check("count_three", 32'(count), 32'(3));
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
    idle(1);

    // Fill to full, overflow attempt, drain (pointers wrap).
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 0);
    check("count_full", 32'(count), 32'(DEPTH));
    cycle(1, 8'hAA, 0, 0);
    check("overflow_set", 32'(overflow), 32'(1));
    cycle(1, 8'hAB, 1, 0); // full blocks push even with a pop
    for (int i = 0; i < DEPTH; i++) cycle(0, '0, 1, 0);
    idle(1);
    cycle(0, '0, 0, 1);

    // Hold occupancy at 10 with simultaneous push/pop.
    for (int i = 0; i < 10; i++) cycle(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 100; i++) cycle(1, 8'($urandom), 1, 0);
    check("count_steady", 32'(count), 32'(10));

    // Drain, underflow, flush.
    for (int i = 0; i < 12; i++) cycle(0, '0, 1, 0);
    check("underflow_set", 32'(underflow), 32'(1));
    cycle(0, '0, 0, 1);
    check("underflow_clr", 32'(underflow), 32'(0));

    // Reset mid-stream with 5 words held.
    for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 0, 0);
    cycle(1, 8'h5A, 1, 0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'($urandom), 1, 0);

    // Random traffic with occasional flush.
    for (int i = 0; i < 600; i++) begin
      n = $urandom_range(0, 99);
      cycle(1'($urandom_range(0, 99) < 55), 8'($urandom),
            1'($urandom_range(0, 99) < 50), 1'(n < 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
